// File: rtl/sha256d_nonce_feeder_pkg.sv
// Shared definitions for the sha256d nonce feeder and hasher wrapper.
// FSM encoding, header geometry and byte-reverse helpers.
package sha256d_nonce_feeder_pkg;

    localparam int HDR_WORDS  = 20;
    localparam int NONCE_WORD = 19;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_CHECK
    } feeder_state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [255:0] bswap256(input logic [255:0] w);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[8*i +: 8] = w[8*(31-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha256d_nonce_feeder_hdr_word_ram.sv
// Header word store: 20x32 registers, one write port, one registered read.
// Reads beyond the header return zero.
module hdr_word_ram
    import sha256d_nonce_feeder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        re,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata
);

    localparam logic [4:0] LIM = 5'(HDR_WORDS);

    logic [31:0] mem [HDR_WORDS];

    // Header contents survive reset; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (we && waddr < LIM) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port, zero for indices past the header.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (raddr < LIM) ? mem[raddr] : 32'd0;
        end
    end

endmodule

// File: rtl/sha256d_nonce_feeder.sv
// Serves the block header to the sha256d hasher with a live nonce,
// checks each hash against a target and steps the nonce until done.
module sha256d_nonce_feeder
    import sha256d_nonce_feeder_pkg::*;
#(
    parameter bit NONCE_SWAP = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_we,
    input  logic [4:0]   cfg_addr,
    input  logic [31:0]  cfg_wdata,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [255:0] target,
    input  logic         run,
    input  logic         stop,
    output logic         h_start,
    input  logic         h_rq,
    input  logic [4:0]   h_addr,
    output logic         h_rdy,
    output logic [31:0]  h_data,
    input  logic [255:0] h_hash,
    input  logic         h_done,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic [31:0]  nonce_out,
    output logic [255:0] hash_out
);

    feeder_state_t state;
    logic [31:0]   nonce;
    logic [31:0]   end_q;
    logic [255:0]  tgt_q;
    logic          stop_pend;
    logic          done_q;
    logic          sel_nonce;
    logic [31:0]   nonce_bus;
    logic [31:0]   ram_q;
    logic          done_rise;
    logic          hit;

    assign done_rise = h_done & ~done_q;
    assign hit       = bswap256(hash_out) <= tgt_q;
    assign h_data    = sel_nonce ? nonce_bus : ram_q;

    hdr_word_ram u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_we & ~busy),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .re    (h_rq),
        .raddr (h_addr),
        .rdata (ram_q)
    );

    // Bus response: capture the nonce word alongside the RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_rdy     <= 1'b0;
            sel_nonce <= 1'b0;
            nonce_bus <= '0;
            done_q    <= 1'b0;
        end else begin
            h_rdy  <= h_rq;
            done_q <= h_done;
            if (h_rq) begin
                sel_nonce <= h_addr == 5'(NONCE_WORD);
                nonce_bus <= NONCE_SWAP ? bswap32(nonce) : nonce;
            end
        end
    end

    // Search sequencer: launch, wait for the hash, check, step nonce.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            nonce     <= '0;
            end_q     <= '0;
            tgt_q     <= '0;
            stop_pend <= 1'b0;
            h_start   <= 1'b0;
            busy      <= 1'b0;
            found     <= 1'b0;
            exhausted <= 1'b0;
            nonce_out <= '0;
            hash_out  <= '0;
        end else begin
            if (stop && state != ST_IDLE) begin
                stop_pend <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (run) begin
                        nonce     <= nonce_start;
                        end_q     <= nonce_end;
                        tgt_q     <= target;
                        found     <= 1'b0;
                        exhausted <= 1'b0;
                        stop_pend <= 1'b0;
                        busy      <= 1'b1;
                        h_start   <= 1'b1;
                        state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    h_start <= 1'b0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_rise) begin
                        hash_out  <= h_hash;
                        nonce_out <= nonce;
                        state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (hit) begin
                        found     <= 1'b1;
                        busy      <= 1'b0;
                        stop_pend <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (nonce == end_q) begin
                        exhausted <= 1'b1;
                        busy      <= 1'b0;
                        stop_pend <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (stop_pend || stop) begin
                        busy      <= 1'b0;
                        stop_pend <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        nonce   <= nonce + 32'd1;
                        h_start <= 1'b1;
                        state   <= ST_LAUNCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256d_nonce_feeder.sv
// Scoreboarded bench for sha256d_nonce_feeder with a behavioural
// hasher stand-in and a plain-arithmetic search model.
module tb_sha256d_nonce_feeder;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_we;
    logic [4:0]   cfg_addr;
    logic [31:0]  cfg_wdata;
    logic [31:0]  nonce_start;
    logic [31:0]  nonce_end;
    logic [255:0] target;
    logic         run;
    logic         stop;
    logic         h_start;
    logic         h_rq;
    logic [4:0]   h_addr;
    logic         h_rdy;
    logic [31:0]  h_data;
    logic [255:0] h_hash;
    logic         h_done;
    logic         busy;
    logic         found;
    logic         exhausted;
    logic [31:0]  nonce_out;
    logic [255:0] hash_out;

    logic         tst_mode;
    logic         m_rq, t_rq, m_done, t_done;
    logic [4:0]   m_addr, t_addr;
    logic [255:0] m_hash;

    assign h_rq   = tst_mode ? t_rq : m_rq;
    assign h_addr = tst_mode ? t_addr : m_addr;
    assign h_done = tst_mode ? t_done : m_done;
    assign h_hash = m_hash;

    sha256d_nonce_feeder dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .nonce_start(nonce_start),
        .nonce_end(nonce_end), .target(target), .run(run), .stop(stop),
        .h_start(h_start), .h_rq(h_rq), .h_addr(h_addr), .h_rdy(h_rdy),
        .h_data(h_data), .h_hash(h_hash), .h_done(h_done), .busy(busy),
        .found(found), .exhausted(exhausted), .nonce_out(nonce_out),
        .hash_out(hash_out)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] WIN_REV =
        256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
    localparam logic [255:0] GEN_TGT = 256'h0000_0000_FFFF << 208;

    typedef struct packed {
        logic         f;
        logic         e;
        logic [31:0]  n;
        logic [255:0] h;
    } res_t;

    int          total = 0;
    int          bad = 0;
    int          starts_seen = 0;
    logic [31:0] hdr [20];
    logic [31:0] fw [20];
    logic [31:0] win;
    logic [31:0] exp_last;
    logic [31:0] q_att [$];
    res_t        q_res [$];

    task automatic chk(input string name, input logic [255:0] got,
                       input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = x[8*(3-i) +: 8];
        return r;
    endfunction

    function automatic logic [255:0] rev256(input logic [255:0] x);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = x[8*(31-i) +: 8];
        return r;
    endfunction

    // Byte-reversed digest the stand-in hasher produces for a nonce.
    function automatic logic [255:0] rev_of(input logic [31:0] n);
        if (n == win) return WIN_REV;
        return {1'b1, n[30:0] ^ 31'h2a5c_1e37, {7{n ^ 32'h9e37_79b9}}};
    endfunction

    // Search model: walk nonces, stop on hit, end of range or stop limit.
    task automatic model(input logic [31:0] s, input logic [31:0] e,
                         input logic [255:0] t, input int max_att);
        res_t        r;
        logic [31:0] n;
        n = s;
        r = '0;
        for (int a = 1; a <= 1000; a++) begin
            q_att.push_back(n);
            r.n = n;
            r.h = rev256(rev_of(n));
            r.f = 1'b0;
            r.e = 1'b0;
            if (rev_of(n) <= t) begin r.f = 1'b1; break; end
            if (n == e) begin r.e = 1'b1; break; end
            if (a == max_att) break;
            n = n + 32'd1;
        end
        q_res.push_back(r);
        exp_last = r.n;
    endtask

    // Stand-in hasher: fetch all words, then report a digest.
    initial begin : hasher
        logic        ok;
        logic [31:0] en;
        m_rq = 1'b0; m_addr = '0; m_done = 1'b0; m_hash = '0;
        forever begin
            @(negedge clk);
            if (!tst_mode && h_start) begin
                starts_seen++;
                ok = 1'b1;
                for (int i = 0; i <= 20; i++) begin
                    if (i > 0) begin
                        fw[i-1] = h_data;
                        if (!h_rdy) ok = 1'b0;
                    end
                    if (i < 20) begin
                        m_rq = 1'b1;
                        m_addr = 5'(i);
                        @(negedge clk);
                    end else begin
                        m_rq = 1'b0;
                    end
                end
                for (int i = 0; i < 19; i++) if (fw[i] !== hdr[i]) ok = 1'b0;
                chk("hdr_fetch", 256'(ok), 256'(1));
                chk("start_expected", 256'(q_att.size() > 0), 256'(1));
                if (q_att.size() > 0) begin
                    en = q_att.pop_front();
                    chk("word19", 256'(fw[19]), 256'(rev32(en)));
                end
                repeat ($urandom_range(1, 6)) @(negedge clk);
                m_hash = rev256(rev_of(rev32(fw[19])));
                m_done = 1'b1;
                @(negedge clk);
                m_done = 1'b0;
            end
        end
    end

    // Result monitor: score each completed search.
    initial begin : monitor
        logic pb;
        res_t r;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (!tst_mode && pb && !busy) begin
                chk("res_q_depth", 256'(q_res.size()), 256'(1));
                if (q_res.size() > 0) begin
                    r = q_res.pop_front();
                    chk("found", 256'(found), 256'(r.f));
                    chk("exhausted", 256'(exhausted), 256'(r.e));
                    chk("nonce_out", 256'(nonce_out), 256'(r.n));
                    chk("hash_out", hash_out, r.h);
                    chk("attempts_left", 256'(q_att.size()), 256'(0));
                end
            end
            pb = busy;
        end
    end

    task automatic search(input logic [31:0] s, input logic [31:0] e,
                          input logic [255:0] t, input int max_att,
                          input int stop_after, input bit poke,
                          input bit rerun);
        int base;
        int cyc;
        model(s, e, t, max_att);
        base = starts_seen;
        nonce_start = s; nonce_end = e; target = t;
        @(negedge clk) run = 1'b1;
        @(negedge clk) run = 1'b0;
        chk("busy_set", 256'(busy), 256'(1));
        if (rerun) begin
            repeat (3) @(negedge clk);
            nonce_start = s + 32'd100;
            run = 1'b1;
            @(negedge clk) run = 1'b0;
        end
        if (poke) begin
            cfg_we = 1'b1; cfg_addr = 5'd3; cfg_wdata = ~hdr[3];
            @(negedge clk) cfg_we = 1'b0;
        end
        if (stop_after > 0) begin
            cyc = 0;
            while (starts_seen < base + stop_after && cyc < 5000) begin
                @(negedge clk);
                cyc++;
            end
            repeat (3) @(negedge clk);
            stop = 1'b1;
            @(negedge clk) stop = 1'b0;
        end
        cyc = 0;
        while (q_res.size() != 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 20000) begin
            chk("search_timeout", 256'(q_res.size()), 256'(0));
            q_res.delete();
            q_att.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic bus_scan();
        logic [4:0]  a;
        logic [31:0] ex;
        tst_mode = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            a = (i < 20) ? 5'(i) : 5'd25;
            t_rq = 1'b1; t_addr = a;
            @(negedge clk);
            ex = (a == 5'd19) ? rev32(exp_last) : (a < 5'd20) ? hdr[a] : 32'd0;
            chk($sformatf("bus_w%0d", a), 256'({h_rdy, h_data}),
                256'({1'b1, ex}));
        end
        t_rq = 1'b0;
        @(negedge clk);
        chk("bus_rdy_drop", 256'(h_rdy), 256'(0));
        tst_mode = 1'b0;
    endtask

    initial begin : stim
        logic [31:0] s;
        logic [31:0] ln;
        int          ns;
        tst_mode = 1'b0; t_rq = 1'b0; t_addr = '0; t_done = 1'b0;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        nonce_start = '0; nonce_end = '0; target = '0;
        run = 1'b0; stop = 1'b0; win = 32'h7C2B_AC1D; exp_last = '0;
        repeat (3) @(negedge clk);
        chk("rst_outs", 256'({h_start, h_rdy, h_data, busy, found,
            exhausted, nonce_out}), 256'(0));
        chk("rst_hash", hash_out, 256'(0));
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            hdr[i] = $urandom;
            cfg_we = 1'b1; cfg_addr = 5'(i); cfg_wdata = hdr[i];
            @(negedge clk);
        end
        cfg_we = 1'b0;

        search(32'h7C2B_AC1A, 32'h7C2B_AC20, GEN_TGT, 0, 0, 1'b0, 1'b1);
        bus_scan();

        stop = 1'b1;
        @(negedge clk) stop = 1'b0;
        search(32'h0, 32'h3, GEN_TGT, 0, 0, 1'b1, 1'b0);
        bus_scan();

        win = 32'h1234_5678;
        search(32'hFFFF_FFFE, 32'h0000_0001, 256'd0, 0, 0, 1'b0, 1'b0);
        search(32'h0000_1000, 32'h0000_100A, 256'd0, 2, 2, 1'b0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            s = (k % 3 == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                             : $urandom;
            ln = 32'($urandom_range(0, 5));
            win = (k == 0) ? s + ln : s + 32'($urandom_range(0, 7));
            search(s, s + ln, (k % 4 == 3) ? '1 : WIN_REV, 0, 0,
                   1'b0, 1'b0);
        end

        tst_mode = 1'b1;
        nonce_start = 32'h55; nonce_end = 32'h60; target = '0;
        @(negedge clk) run = 1'b1;
        @(negedge clk) run = 1'b0;
        chk("rst_test_launch", 256'(h_start), 256'(1));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        t_done = 1'b1;
        ns = 0;
        repeat (4) begin
            @(negedge clk);
            if (h_start) ns++;
        end
        t_done = 1'b0;
        chk("rst_no_start", 256'(ns), 256'(0));
        chk("rst_mid_outs", 256'({h_start, h_rdy, h_data, busy, found,
            exhausted, nonce_out}), 256'(0));
        chk("rst_mid_hash", hash_out, 256'(0));
        tst_mode = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
